// File: rtl/exe_mem_pipe_buf_pkg.sv
// Shared pipeline definitions for the EXE->MEM stage buffer.
// Provides control-bit indices, default widths and the payload record layout.
package pipe_pkg;

    localparam int CTRL_W       = 3;
    localparam int REG_ADDR_W   = 4;
    localparam int DATA_W       = 32;

    localparam int WB_EN_BIT    = 0;
    localparam int MEM_R_EN_BIT = 1;
    localparam int MEM_W_EN_BIT = 2;

    typedef struct packed {
        logic [CTRL_W-1:0]     ctrl;
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     alu_res;
        logic [DATA_W-1:0]     val_rm;
    } exe_mem_payload_t;

endpackage : pipe_pkg

// File: rtl/exe_mem_pipe_buf_if.sv
// Handshake bundle between EXE, the stage buffer and MEM.
// The hazard-compare signals only exist when HAZARD_CHECK_EN is defined.
interface exe_mem_pipe_buf_if #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CTRL_W = 3,
    parameter int DEPTH  = 2
);
    logic                       flush;
    logic                       freeze;
    logic                       in_valid;
    logic                       in_ready;
    logic [CTRL_W-1:0]          in_ctrl;
    logic [DEST_W-1:0]          in_dest;
    logic [DATA_W-1:0]          in_alu_res;
    logic [DATA_W-1:0]          in_val_rm;
    logic                       out_valid;
    logic                       out_ready;
    logic [CTRL_W-1:0]          out_ctrl;
    logic [DEST_W-1:0]          out_dest;
    logic [DATA_W-1:0]          out_alu_res;
    logic [DATA_W-1:0]          out_val_rm;
    logic [$clog2(DEPTH+1)-1:0] count;
`ifdef HAZARD_CHECK_EN
    logic [DEST_W-1:0]          hz_src1;
    logic [DEST_W-1:0]          hz_src2;
    logic                       hz_hit;
`endif

    // Pipeline side driving the buffer (EXE inputs plus MEM ready).
    modport master (
        output flush, freeze, in_valid, in_ctrl, in_dest, in_alu_res, in_val_rm, out_ready,
        input  in_ready, out_valid, out_ctrl, out_dest, out_alu_res, out_val_rm, count
`ifdef HAZARD_CHECK_EN
        , output hz_src1, hz_src2
        , input  hz_hit
`endif
    );

    // The buffer itself.
    modport slave (
        input  flush, freeze, in_valid, in_ctrl, in_dest, in_alu_res, in_val_rm, out_ready,
        output in_ready, out_valid, out_ctrl, out_dest, out_alu_res, out_val_rm, count
`ifdef HAZARD_CHECK_EN
        , input  hz_src1, hz_src2
        , output hz_hit
`endif
    );

endinterface : exe_mem_pipe_buf_if

// File: rtl/exe_mem_pipe_buf_store.sv
// Payload storage for the stage buffer: one write port, asynchronous read mux.
// With HAZARD_CHECK_EN the whole array is also exposed for the dest compare.
module pipe_buf_store #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 71,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [WIDTH-1:0] rd_data
`ifdef HAZARD_CHECK_EN
    ,
    output logic [WIDTH-1:0] mem_q [DEPTH]
`endif
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Entry array, written at the write pointer on an accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_en) begin
            mem_r[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr];

`ifdef HAZARD_CHECK_EN
    assign mem_q = mem_r;
`endif

endmodule : pipe_buf_store

// File: rtl/exe_mem_pipe_buf.sv
// EXE->MEM elastic stage buffer, DEPTH entries, valid/ready on both sides.
// Optional macro HAZARD_CHECK_EN adds the hz_src1/hz_src2 -> hz_hit compare.
module exe_mem_pipe_buf #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int DEST_W = pipe_pkg::REG_ADDR_W,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int DEPTH  = 2
) (
    input logic                clk,
    input logic                rst,
    exe_mem_pipe_buf_if.slave  bus
);
    import pipe_pkg::*;

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int WIDTH   = CTRL_W + DEST_W + 2 * DATA_W;

    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic [DEPTH-1:0] valid_r, valid_nxt_s;
    logic             full_s, push_s, pop_s, head_valid_s;
    logic [WIDTH-1:0] wr_data_s, rd_data_s;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full_s       = (count_r == CNT_W'(DEPTH));
    assign head_valid_s = (count_r != {CNT_W{1'b0}});
    assign bus.in_ready = !full_s && !bus.freeze && !bus.flush;
    assign push_s       = bus.in_valid && bus.in_ready;
    assign pop_s        = head_valid_s && bus.out_ready && !bus.freeze && !bus.flush;
    assign wr_data_s    = {bus.in_ctrl, bus.in_dest, bus.in_alu_res, bus.in_val_rm};

`ifdef HAZARD_CHECK_EN
    logic [WIDTH-1:0] mem_q_s [DEPTH];
`endif

    pipe_buf_store #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .PTR_W (PTR_W)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_s),
        .wr_ptr  (wr_ptr_r),
        .wr_data (wr_data_s),
        .rd_ptr  (rd_ptr_r),
        .rd_data (rd_data_s)
`ifdef HAZARD_CHECK_EN
        ,
        .mem_q   (mem_q_s)
`endif
    );

    // Next pointer, occupancy and per-entry valid state from push/pop.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        valid_nxt_s  = valid_r;
        count_nxt_s  = count_r;
        if (push_s) begin
            valid_nxt_s[wr_ptr_r] = 1'b1;
            wr_ptr_nxt_s          = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            valid_nxt_s[rd_ptr_r] = 1'b0;
            rd_ptr_nxt_s          = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Control state: flush empties the buffer, freeze holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            valid_r  <= {DEPTH{1'b0}};
        end else if (bus.flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            valid_r  <= {DEPTH{1'b0}};
        end else if (!bus.freeze) begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            valid_r  <= valid_nxt_s;
        end
    end

    // Head presentation; a bubble shows all-zero so MEM never sees stale enables.
    always_comb begin
        bus.out_valid = head_valid_s;
        if (head_valid_s) begin
            {bus.out_ctrl, bus.out_dest, bus.out_alu_res, bus.out_val_rm} = rd_data_s;
        end else begin
            {bus.out_ctrl, bus.out_dest, bus.out_alu_res, bus.out_val_rm} = {WIDTH{1'b0}};
        end
    end

    assign bus.count = count_r;

`ifdef HAZARD_CHECK_EN
    // Any live entry that will write back to a register decode wants to read.
    always_comb begin
        bus.hz_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_r[i] && mem_q_s[i][2*DATA_W + DEST_W + WB_EN_BIT] &&
                ((mem_q_s[i][2*DATA_W +: DEST_W] == bus.hz_src1) ||
                 (mem_q_s[i][2*DATA_W +: DEST_W] == bus.hz_src2))) begin
                bus.hz_hit = 1'b1;
            end else begin
                bus.hz_hit = bus.hz_hit;
            end
        end
    end
`endif

endmodule : exe_mem_pipe_buf

// File: tb/tb_exe_mem_pipe_buf.sv
// Directed bench for exe_mem_pipe_buf (DEPTH=2): vector table plus corner sequences.
module tb_exe_mem_pipe_buf;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    exe_mem_pipe_buf_if #(.DATA_W(32), .DEST_W(4), .CTRL_W(3), .DEPTH(2)) bus ();

    exe_mem_pipe_buf #(.DATA_W(32), .DEST_W(4), .CTRL_W(3), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [2:0]  ic;
        logic [3:0]  id;
        logic [31:0] ia;
        logic [31:0] ir;
        logic        ordy;
        logic        ev;
        logic        erdy;
        int          ecnt;
        logic [2:0]  ec;
        logic [3:0]  ed;
        logic [31:0] ea;
        logic [31:0] er;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [2:0] ic, input logic [3:0] id,
                         input logic [31:0] ia, input logic [31:0] ir, input logic ordy,
                         input logic fl, input logic fz);
        bus.in_valid   = iv;
        bus.in_ctrl    = ic;
        bus.in_dest    = id;
        bus.in_alu_res = ia;
        bus.in_val_rm  = ir;
        bus.out_ready  = ordy;
        bus.flush      = fl;
        bus.freeze     = fz;
    endtask

    task automatic check_empty(input string tag);
        check({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, " count"}, {30'd0, bus.count}, 32'd0);
        check({tag, " out_ctrl"}, {29'd0, bus.out_ctrl}, 32'd0);
        check({tag, " out_dest"}, {28'd0, bus.out_dest}, 32'd0);
        check({tag, " out_alu"}, bus.out_alu_res, 32'd0);
        check({tag, " out_rm"}, bus.out_val_rm, 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        drive(1'b0, 3'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_CHECK_EN
        bus.hz_src1 = 4'd0;
        bus.hz_src2 = 4'd0;
`endif
        // Fill/drain (A, B, rejected C), then streaming through wrapping pointers.
        vecs[0]  = '{1'b1, 3'b001, 4'd3, 32'h11, 32'hA0, 1'b0, 1'b0, 1'b1, 0, 3'b000, 4'd0, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 3'b011, 4'd7, 32'h22, 32'hB0, 1'b0, 1'b1, 1'b1, 1, 3'b001, 4'd3, 32'h11, 32'hA0};
        vecs[2]  = '{1'b1, 3'b111, 4'd9, 32'h33, 32'hC0, 1'b0, 1'b1, 1'b0, 2, 3'b001, 4'd3, 32'h11, 32'hA0};
        vecs[3]  = '{1'b0, 3'b000, 4'd0, 32'h0,  32'h0,  1'b1, 1'b1, 1'b0, 2, 3'b001, 4'd3, 32'h11, 32'hA0};
        vecs[4]  = '{1'b0, 3'b000, 4'd0, 32'h0,  32'h0,  1'b1, 1'b1, 1'b1, 1, 3'b011, 4'd7, 32'h22, 32'hB0};
        vecs[5]  = '{1'b0, 3'b000, 4'd0, 32'h0,  32'h0,  1'b0, 1'b0, 1'b1, 0, 3'b000, 4'd0, 32'h0,  32'h0};
        vecs[6]  = '{1'b1, 3'b001, 4'd1, 32'h1,  32'h101, 1'b1, 1'b0, 1'b1, 0, 3'b000, 4'd0, 32'h0, 32'h0};
        vecs[7]  = '{1'b1, 3'b001, 4'd2, 32'h2,  32'h102, 1'b1, 1'b1, 1'b1, 1, 3'b001, 4'd1, 32'h1, 32'h101};
        vecs[8]  = '{1'b1, 3'b001, 4'd3, 32'h3,  32'h103, 1'b1, 1'b1, 1'b1, 1, 3'b001, 4'd2, 32'h2, 32'h102};
        vecs[9]  = '{1'b1, 3'b001, 4'd4, 32'h4,  32'h104, 1'b1, 1'b1, 1'b1, 1, 3'b001, 4'd3, 32'h3, 32'h103};
        vecs[10] = '{1'b1, 3'b001, 4'd5, 32'h5,  32'h105, 1'b1, 1'b1, 1'b1, 1, 3'b001, 4'd4, 32'h4, 32'h104};
        vecs[11] = '{1'b0, 3'b000, 4'd0, 32'h0,  32'h0,   1'b1, 1'b1, 1'b1, 1, 3'b001, 4'd5, 32'h5, 32'h105};
        vecs[12] = '{1'b0, 3'b000, 4'd0, 32'h0,  32'h0,   1'b0, 1'b0, 1'b1, 0, 3'b000, 4'd0, 32'h0, 32'h0};

        #2;
        check_empty("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].ic, vecs[i].id, vecs[i].ia, vecs[i].ir, vecs[i].ordy, 1'b0, 1'b0);
            #1;
            check($sformatf("v%0d out_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].ev});
            check($sformatf("v%0d in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].erdy});
            check($sformatf("v%0d count", i), {30'd0, bus.count}, vecs[i].ecnt);
            check($sformatf("v%0d out_ctrl", i), {29'd0, bus.out_ctrl}, {29'd0, vecs[i].ec});
            check($sformatf("v%0d out_dest", i), {28'd0, bus.out_dest}, {28'd0, vecs[i].ed});
            check($sformatf("v%0d out_alu", i), bus.out_alu_res, vecs[i].ea);
            check($sformatf("v%0d out_rm", i), bus.out_val_rm, vecs[i].er);
        end

        // Flush colliding with a push while full.
        @(negedge clk);
        drive(1'b1, 3'b001, 4'd1, 32'h41, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'b001, 4'd2, 32'h42, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'b001, 4'd3, 32'h43, 32'h0, 1'b1, 1'b1, 1'b0);
        #1;
        check("flush pre count", {30'd0, bus.count}, 32'd2);
        check("flush in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        drive(1'b0, 3'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check_empty("flush bubble");
        @(negedge clk);
        #1;
        check_empty("flush drop");

        // Freeze with a head entry, input valid and MEM ready for three cycles.
        drive(1'b1, 3'b001, 4'd6, 32'hAB, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'b001, 4'd6, 32'hCD, 32'h0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("freeze%0d in_ready", k), {31'd0, bus.in_ready}, 32'd0);
            check($sformatf("freeze%0d count", k), {30'd0, bus.count}, 32'd1);
            check($sformatf("freeze%0d alu", k), bus.out_alu_res, 32'hAB);
            @(negedge clk);
        end
        drive(1'b0, 3'd0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        #1;
        check("unfreeze valid", {31'd0, bus.out_valid}, 32'd1);
        check("unfreeze alu", bus.out_alu_res, 32'hAB);
        @(negedge clk);
        drive(1'b0, 3'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check_empty("after unfreeze pop");

        // Asynchronous reset between clock edges with two entries held.
        @(negedge clk);
        drive(1'b1, 3'b011, 4'd4, 32'h51, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'b011, 4'd4, 32'h52, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 3'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("prereset count", {30'd0, bus.count}, 32'd2);
        #1;
        rst = 1'b1;
        #1;
        check_empty("async reset");
        #1;
        rst = 1'b0;
        @(negedge clk);
        drive(1'b1, 3'b001, 4'd8, 32'h61, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 3'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("post reset count", {30'd0, bus.count}, 32'd1);
        check("post reset alu", bus.out_alu_res, 32'h61);

`ifdef HAZARD_CHECK_EN
        // Flush, then a single WB entry to dest 5.
        @(negedge clk);
        drive(1'b0, 3'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'b001, 4'd5, 32'h71, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 3'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        bus.hz_src1 = 4'd5;
        bus.hz_src2 = 4'd0;
        #1;
        check("hz src1 hit", {31'd0, bus.hz_hit}, 32'd1);
        bus.hz_src1 = 4'd0;
        bus.hz_src2 = 4'd6;
        #1;
        check("hz src2 miss", {31'd0, bus.hz_hit}, 32'd0);
        bus.hz_src2 = 4'd5;
        #1;
        check("hz src2 hit", {31'd0, bus.hz_hit}, 32'd1);
        @(negedge clk);
        drive(1'b0, 3'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'b010, 4'd5, 32'h72, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check("hz after flush", {31'd0, bus.hz_hit}, 32'd0);
        @(negedge clk);
        drive(1'b0, 3'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        bus.hz_src1 = 4'd5;
        #1;
        check("hz wb off", {31'd0, bus.hz_hit}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_exe_mem_pipe_buf
